// File: rtl/syn_fgyrus_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : syn_fgyrus_mem_arb
// Desc   : Shares one single-port coefficient RAM between the FFT sequencer
//          and the local-bus path, returning read data to the issuing side.
// Rev    : 1.0  initial release
// ============================================================================
module syn_fgyrus_mem_arb #(
  parameter int P_DATA_W     = 32,
  parameter int P_ADDR_W     = 7,
  parameter int P_MEM_RD_DEL = 2,
  parameter int P_STARVE_MAX = 8
) (
  input  logic                clk_ir,
  input  logic                rst_sync_l,
  input  logic                fsm_lock,
  input  logic                fsm_rden,
  input  logic                fsm_wren,
  input  logic [P_ADDR_W-1:0] fsm_addr,
  input  logic [P_DATA_W-1:0] fsm_wdata,
  output logic                fsm_gnt,
  output logic                fsm_rd_valid,
  output logic [P_DATA_W-1:0] fsm_rdata,
  input  logic                lb_rden,
  input  logic                lb_wren,
  input  logic [P_ADDR_W-1:0] lb_addr,
  input  logic [P_DATA_W-1:0] lb_wdata,
  output logic                lb_gnt,
  output logic                lb_rd_valid,
  output logic [P_DATA_W-1:0] lb_rdata,
  output logic                mem_rden,
  output logic                mem_wren,
  output logic [P_ADDR_W-1:0] mem_addr,
  output logic [P_DATA_W-1:0] mem_wdata,
  input  logic [P_DATA_W-1:0] mem_rdata,
  output logic                lb_starved
);

  localparam int C_CNT_W  = $clog2(P_STARVE_MAX + 1);
  localparam int C_PIPE_D = 1 + P_MEM_RD_DEL;
  localparam logic [C_CNT_W-1:0] C_STARVE_MAX = C_CNT_W'(P_STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FSM_OWN = 2'd1,
    ST_LB_OWN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                w_fsm_req;
  logic                w_lb_req;
  logic                w_fsm_win;
  logic                w_lb_win;
  logic                w_any_gnt;
  logic                w_sel_wr;
  logic                w_sel_rd;
  logic [P_ADDR_W-1:0] w_sel_addr;
  logic [P_DATA_W-1:0] w_sel_wdata;
  logic [C_CNT_W-1:0]  r_lb_wait_cnt;
  logic [C_PIPE_D-1:0] r_vld_pipe;
  logic [C_PIPE_D-1:0] r_own_pipe;

  assign w_fsm_req = fsm_rden | fsm_wren;
  assign w_lb_req  = lb_rden | lb_wren;

  // Grants are masked by reset so nothing is accepted while the block is held.
  always_comb begin
    w_lb_win    = 1'b0;
    w_fsm_win   = 1'b0;
    w_state_nxt = ST_IDLE;
    w_lb_win    = rst_sync_l & w_lb_req & ~fsm_lock &
                  ((r_lb_wait_cnt == C_STARVE_MAX) | ~w_fsm_req);
    w_fsm_win   = rst_sync_l & w_fsm_req & ~w_lb_win;
    case (r_state)
      ST_IDLE, ST_FSM_OWN, ST_LB_OWN: begin
        if (w_lb_win)       w_state_nxt = ST_LB_OWN;
        else if (w_fsm_win) w_state_nxt = ST_FSM_OWN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign fsm_gnt     = w_fsm_win;
  assign lb_gnt      = w_lb_win;
  assign w_any_gnt   = w_fsm_win | w_lb_win;
  assign w_sel_wr    = w_lb_win ? lb_wren : fsm_wren;
  // A write that is illegally paired with a read wins; the read is dropped.
  assign w_sel_rd    = (w_lb_win ? lb_rden : fsm_rden) & ~w_sel_wr;
  assign w_sel_addr  = w_lb_win ? lb_addr : fsm_addr;
  assign w_sel_wdata = w_lb_win ? lb_wdata : fsm_wdata;

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      r_lb_wait_cnt <= '0;
      lb_starved    <= 1'b0;
    end else begin
      if (!w_lb_req || w_lb_win) begin
        r_lb_wait_cnt <= '0;
      end else if (r_lb_wait_cnt != C_STARVE_MAX) begin
        r_lb_wait_cnt <= r_lb_wait_cnt + C_CNT_W'(1);
      end
      if (w_lb_win && w_fsm_req) begin
        lb_starved <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      mem_rden   <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_vld_pipe <= '0;
      r_own_pipe <= '0;
    end else begin
      mem_rden <= w_any_gnt & w_sel_rd;
      mem_wren <= w_any_gnt & w_sel_wr;
      if (w_any_gnt) begin
        mem_addr  <= w_sel_addr;
        mem_wdata <= w_sel_wdata;
      end
      // Owner bit: 1 marks a local-bus read.
      r_vld_pipe <= {r_vld_pipe[C_PIPE_D-2:0], w_any_gnt & w_sel_rd};
      r_own_pipe <= {r_own_pipe[C_PIPE_D-2:0], w_lb_win};
    end
  end

  assign fsm_rd_valid = r_vld_pipe[C_PIPE_D-1] & ~r_own_pipe[C_PIPE_D-1];
  assign lb_rd_valid  = r_vld_pipe[C_PIPE_D-1] &  r_own_pipe[C_PIPE_D-1];
  assign fsm_rdata    = fsm_rd_valid ? mem_rdata : '0;
  assign lb_rdata     = lb_rd_valid  ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_syn_fgyrus_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_syn_fgyrus_mem_arb
// Desc   : Self-checking bench with a RAM model and a queue-based reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_syn_fgyrus_mem_arb;
  localparam int DW = 32, AW = 7, DEL = 2, SMAX = 8, DEPTH = 128;

  logic          clk_ir = 1'b0;
  logic          rst_sync_l = 1'b0;
  logic          fsm_lock, fsm_rden, fsm_wren, lb_rden, lb_wren;
  logic [AW-1:0] fsm_addr, lb_addr, mem_addr;
  logic [DW-1:0] fsm_wdata, lb_wdata, mem_wdata, mem_rdata, fsm_rdata, lb_rdata;
  logic          fsm_gnt, fsm_rd_valid, lb_gnt, lb_rd_valid;
  logic          mem_rden, mem_wren, lb_starved;

  syn_fgyrus_mem_arb #(
    .P_DATA_W(DW), .P_ADDR_W(AW), .P_MEM_RD_DEL(DEL), .P_STARVE_MAX(SMAX)
  ) dut (
    .clk_ir(clk_ir), .rst_sync_l(rst_sync_l), .fsm_lock(fsm_lock),
    .fsm_rden(fsm_rden), .fsm_wren(fsm_wren), .fsm_addr(fsm_addr),
    .fsm_wdata(fsm_wdata), .fsm_gnt(fsm_gnt), .fsm_rd_valid(fsm_rd_valid),
    .fsm_rdata(fsm_rdata), .lb_rden(lb_rden), .lb_wren(lb_wren),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata), .lb_gnt(lb_gnt),
    .lb_rd_valid(lb_rd_valid), .lb_rdata(lb_rdata), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_starved(lb_starved)
  );

  always #5 clk_ir = ~clk_ir;

  function automatic logic [DW-1:0] init_word(int a);
    return (32'(a) * 32'h0001_0203) ^ 32'hC0DE_0000;
  endfunction

  // RAM model: read data appears DEL cycles after the mem_rden cycle.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] rd_q [DEL];
  logic          ram_load = 1'b1;

  always @(posedge clk_ir) begin
    if (ram_load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    rd_q[0] <= mem_rden ? ram[mem_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < DEL; i++) rd_q[i] <= rd_q[i-1];
  end
  assign mem_rdata = rd_q[DEL-1];

  // Reference model
  typedef struct { int due; bit own; logic [DW-1:0] data; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] shadow [DEPTH];
  int            m_wait;
  bit            m_starved, m_rden, m_wren;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            cyc, tests_run, tests_failed;

  function automatic bit e_lb_gnt();
    return rst_sync_l && (lb_rden || lb_wren) && !fsm_lock &&
           (m_wait == SMAX || !(fsm_rden || fsm_wren));
  endfunction

  function automatic bit e_fsm_gnt();
    return rst_sync_l && (fsm_rden || fsm_wren) && !e_lb_gnt();
  endfunction

  function automatic bit e_rdv(bit own);
    return rq.size() != 0 && rq[0].due == cyc && rq[0].own == own;
  endfunction

  function automatic logic [DW-1:0] e_rdata(bit own);
    return e_rdv(own) ? rq[0].data : '0;
  endfunction

  task automatic model_reset();
    rq.delete();
    m_wait = 0; m_starved = 0; m_rden = 0; m_wren = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic set_idle();
    fsm_rden = 0; fsm_wren = 0; fsm_addr = '0; fsm_wdata = '0;
    lb_rden = 0; lb_wren = 0; lb_addr = '0; lb_wdata = '0;
  endtask

  // Advance one clock, updating the model from the inputs of the ending cycle.
  task automatic tick();
    bit lw, fw, wr, rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(posedge clk_ir);
    if (!rst_sync_l) begin
      model_reset();
    end else begin
      lw = e_lb_gnt();
      fw = e_fsm_gnt();
      wr = lw ? lb_wren : fsm_wren;
      rd = (lw ? lb_rden : fsm_rden) && !wr;
      a  = lw ? lb_addr : fsm_addr;
      d  = lw ? lb_wdata : fsm_wdata;
      m_rden = (lw || fw) && rd;
      m_wren = (lw || fw) && wr;
      if (lw || fw) begin
        m_addr = a; m_wdata = d;
        if (wr) shadow[a] = d;
        if (rd) rq.push_back('{due: cyc + 1 + DEL, own: lw, data: shadow[a]});
      end
      if (lw && (fsm_rden || fsm_wren)) m_starved = 1;
      if (!(lb_rden || lb_wren) || lw) m_wait = 0;
      else if (m_wait < SMAX) m_wait++;
      if (rq.size() != 0 && rq[0].due == cyc) void'(rq.pop_front());
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_sync_l = 0; ram_load = 1;
    set_idle(); fsm_rden = 1; lb_wren = 1;
    repeat (3) tick();
    #4;
    tests_run++;
    if ({fsm_gnt, lb_gnt, mem_rden, mem_wren, fsm_rd_valid, lb_rd_valid, lb_starved} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {fsm_gnt, lb_gnt, mem_rden, mem_wren, fsm_rd_valid, lb_rd_valid, lb_starved});
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0 || fsm_rdata !== '0 || lb_rdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h frd=%h lrd=%h required all 0",
               mem_addr, mem_wdata, fsm_rdata, lb_rdata);
    end
    tick();
    rst_sync_l = 1; ram_load = 0; set_idle();
    tick();
  endtask

  task automatic test_single_read();
    fsm_rden = 1; fsm_addr = 7'h05;
    #4;
    tests_run++;
    if (fsm_gnt !== 1'b1 || lb_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_gnt: fsm_gnt=%b lb_gnt=%b required 1/0", fsm_gnt, lb_gnt);
    end
    tick(); fsm_rden = 0; #4;
    tests_run++;
    if (mem_rden !== 1'b1 || mem_wren !== 1'b0 || mem_addr !== 7'h05) begin
      tests_failed++;
      $display("FAIL single_cmd: rden=%b wren=%b addr=%h required 1/0/05", mem_rden, mem_wren, mem_addr);
    end
    tick(); #4;
    tests_run++;
    if (fsm_rd_valid !== 1'b0 || mem_rden !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early: rd_valid=%b mem_rden=%b required 0/0", fsm_rd_valid, mem_rden);
    end
    tick(); #4;
    tests_run++;
    if (fsm_rd_valid !== 1'b1 || fsm_rdata !== shadow[5] || lb_rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ret: valid=%b data=%h lb_valid=%b required 1/%h/0",
               fsm_rd_valid, fsm_rdata, lb_rd_valid, shadow[5]);
    end
    tick(); #4;
    tests_run++;
    if (fsm_rd_valid !== 1'b0 || fsm_rdata !== '0) begin
      tests_failed++;
      $display("FAIL single_pulse: valid=%b data=%h required 0/0", fsm_rd_valid, fsm_rdata);
    end
    tick();
  endtask

  task automatic test_dual_write();
    fsm_wren = 1; fsm_addr = 7'h10; fsm_wdata = 32'hAAAA_5555;
    lb_wren = 1; lb_addr = 7'h11; lb_wdata = 32'h1234_5678;
    #4;
    tests_run++;
    if (fsm_gnt !== 1'b1 || lb_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL dual_first: fsm_gnt=%b lb_gnt=%b required 1/0", fsm_gnt, lb_gnt);
    end
    tick(); fsm_wren = 0; #4;
    tests_run++;
    if (lb_gnt !== 1'b1 || fsm_gnt !== 1'b0 || mem_wren !== 1'b1 || mem_addr !== 7'h10 ||
        mem_wdata !== 32'hAAAA_5555) begin
      tests_failed++;
      $display("FAIL dual_w1: lb_gnt=%b wren=%b addr=%h data=%h required 1/1/10/aaaa5555",
               lb_gnt, mem_wren, mem_addr, mem_wdata);
    end
    tick(); lb_wren = 0; #4;
    tests_run++;
    if (mem_wren !== 1'b1 || mem_addr !== 7'h11 || mem_wdata !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL dual_w2: wren=%b addr=%h data=%h required 1/11/12345678", mem_wren, mem_addr, mem_wdata);
    end
    tick(); #4;
    tests_run++;
    if (mem_wren !== 1'b0 || mem_rden !== 1'b0 || mem_addr !== 7'h11) begin
      tests_failed++;
      $display("FAIL dual_idle: wren=%b rden=%b addr=%h required 0/0/11 held", mem_wren, mem_rden, mem_addr);
    end
    tick();
  endtask

  task automatic test_interleave();
    logic [DW-1:0] e [4];
    logic [DW-1:0] ed;
    bit fv, lv;
    for (int i = 0; i < 4; i++) e[i] = shadow[i+1];
    for (int c = 0; c < 8; c++) begin
      fsm_rden = (c == 0 || c == 2); fsm_addr = (c == 0) ? 7'd1 : 7'd3;
      lb_rden  = (c == 1 || c == 3); lb_addr  = (c == 1) ? 7'd2 : 7'd4;
      #4;
      tests_run++;
      if (fsm_gnt !== (c == 0 || c == 2) || lb_gnt !== (c == 1 || c == 3)) begin
        tests_failed++;
        $display("FAIL ilv_gnt c=%0d: fsm_gnt=%b lb_gnt=%b", c, fsm_gnt, lb_gnt);
      end
      fv = (c == 3 || c == 5);
      lv = (c == 4 || c == 6);
      ed = (c >= 3 && c <= 6) ? e[c-3] : '0;
      tests_run++;
      if (fsm_rd_valid !== fv || lb_rd_valid !== lv ||
          fsm_rdata !== (fv ? ed : '0) || lb_rdata !== (lv ? ed : '0)) begin
        tests_failed++;
        $display("FAIL ilv_ret c=%0d: fv=%b lv=%b fd=%h ld=%h required %b/%b data %h",
                 c, fsm_rd_valid, lb_rd_valid, fsm_rdata, lb_rdata, fv, lv, ed);
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_starvation();
    int k_gnt;
    logic fsm_at;
    #4;
    tests_run++;
    if (lb_starved !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve_pre: lb_starved=%b required 0", lb_starved);
    end
    tick();
    fsm_wren = 1; fsm_addr = 7'h50; fsm_wdata = $urandom;
    lb_rden = 1; lb_addr = 7'h40;
    for (int rep = 0; rep < 2; rep++) begin
      k_gnt = 0; fsm_at = 1'b1;
      for (int k = 1; k <= 12 && k_gnt == 0; k++) begin
        #4;
        if (k == 1) begin
          tests_run++;
          if (fsm_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL starve_fsm_first rep=%0d: fsm_gnt=%b required 1", rep, fsm_gnt);
          end
        end
        if (lb_gnt === 1'b1) begin k_gnt = k; fsm_at = fsm_gnt; end
        tick();
      end
      tests_run++;
      if (k_gnt != 9 || fsm_at !== 1'b0) begin
        tests_failed++;
        $display("FAIL starve_gnt rep=%0d: lb_gnt on wait cycle %0d fsm_gnt=%b required 9/0",
                 rep, k_gnt, fsm_at);
      end
      tests_run++;
      if (lb_starved !== 1'b1) begin
        tests_failed++;
        $display("FAIL starve_flag rep=%0d: lb_starved=%b required 1", rep, lb_starved);
      end
      lb_addr = lb_addr + 7'd1;
    end
    set_idle();
    repeat (6) tick();
  endtask

  task automatic test_lock();
    bit seen = 0;
    fsm_lock = 1; fsm_wren = 1; fsm_addr = 7'h51; fsm_wdata = $urandom;
    lb_rden = 1; lb_addr = 7'h42;
    for (int k = 0; k < 20; k++) begin
      #4;
      if (lb_gnt !== 1'b0 || fsm_gnt !== 1'b1) seen = 1;
      tick();
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL lock_hold: lb granted or fsm blocked while locked, required lb_gnt=0 fsm_gnt=1");
    end
    fsm_lock = 0; #4;
    tests_run++;
    if (lb_gnt !== 1'b1 || fsm_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_release: lb_gnt=%b fsm_gnt=%b required 1/0", lb_gnt, fsm_gnt);
    end
    tick();
    set_idle();
    repeat (6) tick();
  endtask

  task automatic test_reset_inflight();
    fsm_rden = 1; fsm_addr = 7'h21; #4; tick();
    fsm_rden = 0; lb_rden = 1; lb_addr = 7'h22; #4; tick();
    lb_rden = 0;
    #2;
    rst_sync_l = 0; model_reset();
    fsm_rden = 1; fsm_addr = 7'h30;
    #1;
    tests_run++;
    if ({fsm_gnt, lb_gnt, mem_rden, mem_wren, fsm_rd_valid, lb_rd_valid, lb_starved} !== 7'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      tests_failed++;
      $display("FAIL rst_async: ctrl=%b addr=%h wdata=%h required all 0",
               {fsm_gnt, lb_gnt, mem_rden, mem_wren, fsm_rd_valid, lb_rd_valid, lb_starved},
               mem_addr, mem_wdata);
    end
    tick();
    rst_sync_l = 1;
    #4;
    tests_run++;
    if (fsm_gnt !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_first_gnt: fsm_gnt=%b required 1", fsm_gnt);
    end
    tick();
    fsm_rden = 0;
    for (int k = 1; k < 7; k++) begin
      #4;
      tests_run++;
      if (lb_rd_valid !== 1'b0 || fsm_rd_valid !== (k == 3) || fsm_rdata !== e_rdata(0)) begin
        tests_failed++;
        $display("FAIL rst_drop k=%0d: fv=%b lv=%b fd=%h required %b/0/%h",
                 k, fsm_rd_valid, lb_rd_valid, fsm_rdata, (k == 3), e_rdata(0));
      end
      tick();
    end
  endtask

  task automatic new_req(output logic rd, output logic wr, output logic [AW-1:0] a,
                         output logic [DW-1:0] d);
    int op;
    rd = 0; wr = 0;
    a = AW'($urandom_range(0, 7));
    d = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      op = $urandom_range(0, 15);
      rd = (op < 7) || (op == 15);
      wr = (op >= 7);
    end
  endtask

  task automatic test_random();
    bit gf, gl;
    set_idle();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 31) == 0) fsm_lock = ~fsm_lock;
      #4;
      gf = e_fsm_gnt();
      gl = e_lb_gnt();
      tests_run++;
      if (fsm_gnt !== gf || lb_gnt !== gl) begin
        tests_failed++;
        $display("FAIL rnd_gnt n=%0d: fsm_gnt=%b lb_gnt=%b required %b/%b", n, fsm_gnt, lb_gnt, gf, gl);
      end
      tests_run++;
      if (mem_rden !== m_rden || mem_wren !== m_wren || mem_addr !== m_addr || mem_wdata !== m_wdata) begin
        tests_failed++;
        $display("FAIL rnd_cmd n=%0d: rd=%b wr=%b a=%h d=%h required %b/%b/%h/%h",
                 n, mem_rden, mem_wren, mem_addr, mem_wdata, m_rden, m_wren, m_addr, m_wdata);
      end
      tests_run++;
      if (fsm_rd_valid !== e_rdv(0) || fsm_rdata !== e_rdata(0) ||
          lb_rd_valid !== e_rdv(1) || lb_rdata !== e_rdata(1)) begin
        tests_failed++;
        $display("FAIL rnd_ret n=%0d: fv=%b fd=%h lv=%b ld=%h required %b/%h/%b/%h", n,
                 fsm_rd_valid, fsm_rdata, lb_rd_valid, lb_rdata,
                 e_rdv(0), e_rdata(0), e_rdv(1), e_rdata(1));
      end
      tests_run++;
      if (lb_starved !== m_starved) begin
        tests_failed++;
        $display("FAIL rnd_starved n=%0d: lb_starved=%b required %b", n, lb_starved, m_starved);
      end
      tick();
      if (gf || !(fsm_rden || fsm_wren)) new_req(fsm_rden, fsm_wren, fsm_addr, fsm_wdata);
      if (gl || !(lb_rden || lb_wren))   new_req(lb_rden, lb_wren, lb_addr, lb_wdata);
    end
    set_idle();
    fsm_lock = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    cyc = 0; tests_run = 0; tests_failed = 0;
    fsm_lock = 0;
    set_idle();
    model_reset();
    test_reset();
    test_single_read();
    test_dual_write();
    test_interleave();
    test_starvation();
    test_lock();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within 200000 time units");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire

// File: doc/syn_fgyrus_mem_arb.md
Name: syn_fgyrus_mem_arb

Overview:
- Two-requester arbiter that shares one single-port coefficient RAM between the Fusiform Gyrus FFT sequencer and the local-bus (LB) config path.
- Typical targets are the window, twiddle or CORDIC RAM.
- Issues registered RAM commands, tracks in-flight reads with a tag pipeline, and returns read data to the originating requester.
- Bounds LB starvation; lets the sequencer lock the RAM across FFT passes.

Parameters:
- P_DATA_W, 32, RAM data width
- P_ADDR_W, 7, RAM address width
- P_MEM_RD_DEL, 2, RAM read latency in cycles from mem_rden to valid mem_rdata (>=1)
- P_STARVE_MAX, 8, max consecutive cycles a waiting LB request loses to the FSM before it is forced through (>=1)

Ports:
- clk_ir  in  1  clock
- rst_sync_l  in  1  reset, asynchronous assert, active-low
- fsm_lock  in  1  FSM holds exclusive ownership; suppresses LB grants
- fsm_rden, fsm_wren  in  1 each  FSM request; held until fsm_gnt
- fsm_addr  in  P_ADDR_W  FSM address
- fsm_wdata  in  P_DATA_W  FSM write data
- fsm_gnt  out  1  FSM request accepted this cycle
- fsm_rd_valid  out  1  FSM read data valid
- fsm_rdata  out  P_DATA_W  FSM read data
- lb_rden, lb_wren, lb_addr, lb_wdata, lb_gnt, lb_rd_valid, lb_rdata  (same directions and widths)  LB requester
- mem_rden, mem_wren  out  1 each  RAM command
- mem_addr  out  P_ADDR_W  RAM address
- mem_wdata  out  P_DATA_W  RAM write data
- mem_rdata  in  P_DATA_W  RAM read data
- lb_starved  out  1  sticky flag: a forced LB grant has occurred; cleared only by reset

Behaviour:
- Reset (async, rst_sync_l=0):
  - Every output, the tag pipeline and the wait counter clear to 0.
  - FSM state goes to IDLE.
  - Reset mid-read drops the in-flight read: no rd_valid is produced after reset release for reads issued before it.
- Requests:
  - A requester is active when rden or wren is high.
  - rden and wren together is illegal; if it occurs, wren wins and no read is tracked.
  - Requesters hold addr, wdata and the request unchanged until gnt.
  - gnt is combinational and is high for exactly one cycle per accepted request.
- Arbitration FSM, states IDLE, FSM_OWN, LB_OWN; each state names the last grantee.
  - Default priority is FSM over LB.
  - LB wins instead when (lb_wait_cnt == P_STARVE_MAX and fsm_lock=0), or when the FSM is not requesting and fsm_lock=0.
  - When fsm_lock=1, LB is never granted and lb_wait_cnt saturates at P_STARVE_MAX without forcing a grant.
  - Next state follows the winner; with no winner, the state returns to IDLE.
- lb_wait_cnt:
  - Increments when LB is requesting and not granted.
  - Clears on lb_gnt or when LB is idle.
  - Saturates at P_STARVE_MAX.
- Forced grant: an LB grant taken while the FSM is also requesting sets lb_starved.
- Command issue:
  - The granted request is registered onto mem_* on the next clock, giving one cycle of issue latency.
  - mem_rden and mem_wren are low in cycles with no grant.
  - mem_addr and mem_wdata hold their last value when no grant.
- Read return:
  - A 1+P_MEM_RD_DEL-deep shift register carries {valid, owner} for each granted read.
  - X_rd_valid pulses exactly 1+P_MEM_RD_DEL cycles after the X_gnt cycle.
  - X_rdata = mem_rdata when X_rd_valid, else 0.
  - Back-to-back reads from alternating owners return in issue order with no bubbles.
- Throughput: one grant per cycle sustained.
- Write-then-read to the same address on consecutive grants returns the new data; this relies on RAM read-during-write behaviour of new data, which the arbiter does not reorder.

Test Plan:
- Single FSM read at addr 0x05 with P_MEM_RD_DEL=2:
  - fsm_gnt in cycle 0, mem_rden/mem_addr=0x05 in cycle 1.
  - fsm_rd_valid with RAM word in cycle 3; lb_rd_valid stays 0.
- Simultaneous FSM and LB writes (0x10/0xAAAA5555, 0x11/0x12345678):
  - FSM granted first, LB the next cycle.
  - Two mem_wren pulses in consecutive cycles with the correct addr/data.
- FSM requests every cycle, LB read pending, fsm_lock=0, P_STARVE_MAX=8:
  - lb_gnt exactly on the 9th waiting cycle; lb_starved=1.
  - FSM resumes the following cycle; counter back to 0.
- Same as the starvation test with fsm_lock=1 for 20 cycles:
  - No lb_gnt while locked.
  - LB granted in the first cycle after fsm_lock falls.
- Interleaved reads F,L,F,L to addrs 1,2,3,4 in consecutive cycles:
  - rd_valid pulses return in order on the correct ports, 3 cycles after each gnt.
- Assert rst_sync_l low with 2 reads in flight:
  - All outputs 0 immediately.
  - No rd_valid after release; a new request is granted on the first cycle out of reset.
